// File: rtl/oclib_pkg.sv
// rtl/oclib_pkg.sv - shared CSR bus types and defaults
// Request/response structs for the 32-bit CSR bus used by the oclib register blocks.
package oclib_pkg;

  localparam integer DefaultCsrTimeout = 255;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
  } csr_32_s;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } csr_32_fb_s;

endpackage

// File: rtl/oclib_csr_splitter.sv
// rtl/oclib_csr_splitter.sv - address-decoding CSR fan-out with timeout
// Routes one upstream CSR transaction to a target chosen by address bits and returns its response.
module oclib_csr_splitter
  import oclib_pkg::*;
#(
  parameter int NumTargets      = 4,
  parameter int TargetAddrShift = 16,
  parameter int TimeoutCycles   = DefaultCsrTimeout
) (
  input  logic                          clock,
  input  logic                          reset,
  input  csr_32_s                       csr,
  output csr_32_fb_s                    csrFb,
  output csr_32_s    [0:NumTargets-1]   csrOut,
  input  csr_32_fb_s [0:NumTargets-1]   csrOutFb
);

  localparam int IdxW = (NumTargets > 1) ? $clog2(NumTargets) : 1;
  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [31:0] AddrMask = (32'h1 << TargetAddrShift) - 32'h1;

  typedef enum logic [1:0] {Idle, Access, Respond, Drain} state_e;

  state_e          r_state;
  logic [IdxW-1:0] r_idx;
  logic [CntW-1:0] r_cnt;
  logic            r_write;
  csr_32_fb_s      r_fb;

  logic [IdxW-1:0] w_idx;
  logic            w_req;
  logic            w_hit;
  logic            w_launch;
  logic            w_tgt_ready;
  logic            w_timeout;
  logic            w_drop;
  csr_32_fb_s      w_tgt_fb;

  if (NumTargets > 1) begin : g_idx
    assign w_idx = csr.address[TargetAddrShift +: IdxW];
  end else begin : g_idx_zero
    assign w_idx = '0;
  end

  assign w_req       = csr.read | csr.write;
  assign w_hit       = {{(32-IdxW){1'b0}}, w_idx} < 32'(NumTargets);
  assign w_launch    = (r_state == Idle) && (csr.read ^ csr.write) && w_hit;
  assign w_tgt_fb    = csrOutFb[r_idx];
  assign w_tgt_ready = (r_state == Access) && w_tgt_fb.ready;
  assign w_timeout   = (TimeoutCycles != 0) && (r_cnt == CntW'(TimeoutCycles));
  assign w_drop      = (r_state == Access) && (w_tgt_ready || w_timeout);

  // Each port owns its request register; only the decoded port loads, all drop together.
  for (genvar g = 0; g < NumTargets; g++) begin : g_port
    csr_32_s r_port;
    always_ff @(posedge clock) begin
      if (reset) begin
        r_port <= '0;
      end else if (w_launch && (w_idx == IdxW'(g))) begin
        r_port.read    <= csr.read;
        r_port.write   <= csr.write;
        r_port.address <= csr.address & AddrMask;
        r_port.wdata   <= csr.wdata;
      end else if (w_drop) begin
        r_port <= '0;
      end
    end
    assign csrOut[g] = r_port;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= Idle;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_fb    <= '0;
    end else begin
      case (r_state)
        Idle: begin
          r_fb <= '0;
          if (w_req) begin
            r_idx   <= w_idx;
            r_write <= csr.write;
            r_cnt   <= '0;
            if (w_launch) begin
              r_state <= Access;
            end else begin
              r_fb.error <= 1'b1;
              r_state    <= Respond;
            end
          end
        end
        Access: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_tgt_ready) begin
            r_fb.ready <= 1'b1;
            r_fb.error <= w_tgt_fb.error;
            r_fb.rdata <= (r_write || w_tgt_fb.error) ? '0 : w_tgt_fb.rdata;
            r_state    <= Respond;
          end else if (w_timeout) begin
            r_fb.ready <= 1'b1;
            r_fb.error <= 1'b1;
            r_fb.rdata <= '0;
            r_state    <= Respond;
          end
        end
        // A decode miss enters with ready low and spends one extra cycle here.
        Respond: begin
          if (r_fb.ready) begin
            r_fb.ready <= 1'b0;
            r_state    <= Drain;
          end else begin
            r_fb.ready <= 1'b1;
          end
        end
        Drain: begin
          if (!csr.read && !csr.write) begin
            r_fb    <= '0;
            r_state <= Idle;
          end
        end
        default: r_state <= Idle;
      endcase
    end
  end

  assign csrFb = r_fb;

endmodule

// File: tb/tb_oclib_csr_splitter.sv
// tb/tb_oclib_csr_splitter.sv - directed self-checking bench for oclib_csr_splitter
module tb_oclib_csr_splitter;
  import oclib_pkg::*;

  logic                   clock;
  logic                   reset;
  csr_32_s                csr;
  csr_32_fb_s             csrFb;
  csr_32_s    [0:2]       csrOut;
  csr_32_fb_s [0:2]       csrOutFb;

  int errors;
  int checks;

  oclib_csr_splitter #(
    .NumTargets     (3),
    .TargetAddrShift(16),
    .TimeoutCycles  (8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .csr     (csr),
    .csrFb   (csrFb),
    .csrOut  (csrOut),
    .csrOutFb(csrOutFb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    csr = '0;
    csrOutFb = '0;
    tick();
    tick();
    checks++;
    if (csrFb !== '0) begin
      errors++;
      $display("FAIL reset_csrFb got=%h exp=0", csrFb);
    end
    checks++;
    if (csrOut !== '0) begin
      errors++;
      $display("FAIL reset_csrOut got=%h exp=0", csrOut);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read();
    csr.read = 1'b1;
    csr.address = 32'h0002_0008;
    tick();
    checks++;
    if (csrOut[2].read !== 1'b1 || csrOut[2].address !== 32'h0000_0008) begin
      errors++;
      $display("FAIL read_port2_req got rd=%b addr=%h exp rd=1 addr=00000008", csrOut[2].read, csrOut[2].address);
    end
    checks++;
    if (csrOut[0] !== '0 || csrOut[1] !== '0) begin
      errors++;
      $display("FAIL read_other_ports got p0=%h p1=%h exp 0", csrOut[0], csrOut[1]);
    end
    tick();
    csrOutFb[2].ready = 1'b1;
    csrOutFb[2].rdata = 32'hCAFE_0001;
    tick();
    csrOutFb[2] = '0;
    checks++;
    if (csrFb.ready !== 1'b1 || csrFb.rdata !== 32'hCAFE_0001 || csrFb.error !== 1'b0) begin
      errors++;
      $display("FAIL read_response got rdy=%b err=%b rdata=%h exp rdy=1 err=0 rdata=cafe0001", csrFb.ready, csrFb.error, csrFb.rdata);
    end
    checks++;
    if (csrOut[2].read !== 1'b0) begin
      errors++;
      $display("FAIL read_req_dropped got=%b exp=0", csrOut[2].read);
    end
    csr = '0;
    tick();
    checks++;
    if (csrFb.ready !== 1'b0) begin
      errors++;
      $display("FAIL read_ready_one_cycle got=%b exp=0", csrFb.ready);
    end
    tick();
  endtask

  task automatic test_write_hold();
    int wr_seen;
    int rdy_seen;
    csr.write = 1'b1;
    csr.address = 32'h0000_0010;
    csr.wdata = 32'h1234_5678;
    tick();
    checks++;
    if (csrOut[0].write !== 1'b1 || csrOut[0].wdata !== 32'h1234_5678 || csrOut[0].address !== 32'h0000_0010) begin
      errors++;
      $display("FAIL write_req got wr=%b wdata=%h addr=%h exp wr=1 wdata=12345678 addr=00000010", csrOut[0].write, csrOut[0].wdata, csrOut[0].address);
    end
    tick();
    csrOutFb[0].ready = 1'b1;
    csrOutFb[0].rdata = 32'hDEAD_BEEF;
    tick();
    csrOutFb[0] = '0;
    checks++;
    if (csrFb.ready !== 1'b1 || csrFb.rdata !== 32'h0 || csrFb.error !== 1'b0) begin
      errors++;
      $display("FAIL write_response got rdy=%b err=%b rdata=%h exp rdy=1 err=0 rdata=0", csrFb.ready, csrFb.error, csrFb.rdata);
    end
    wr_seen = 0;
    rdy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (csrOut[0].write) wr_seen++;
      if (csrFb.ready) rdy_seen++;
    end
    checks++;
    if (wr_seen !== 0 || rdy_seen !== 0) begin
      errors++;
      $display("FAIL write_hold_no_retrigger got writes=%0d readies=%0d exp 0 0", wr_seen, rdy_seen);
    end
    csr = '0;
    tick();
    tick();
  endtask

  task automatic test_miss(input logic both);
    int busy;
    csr.read = 1'b1;
    csr.write = both;
    csr.address = both ? 32'h0001_0000 : 32'h0003_0000;
    tick();
    checks++;
    if (csrOut !== '0 || csrFb.ready !== 1'b0) begin
      errors++;
      $display("FAIL miss_cycle1 both=%b got out=%h rdy=%b exp out=0 rdy=0", both, csrOut, csrFb.ready);
    end
    tick();
    checks++;
    if (csrFb.ready !== 1'b1 || csrFb.error !== 1'b1 || csrFb.rdata !== 32'h0) begin
      errors++;
      $display("FAIL miss_response both=%b got rdy=%b err=%b rdata=%h exp 1 1 0", both, csrFb.ready, csrFb.error, csrFb.rdata);
    end
    busy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (csrFb.ready !== 1'b0 || csrFb.error !== 1'b1 || csrOut !== '0) busy++;
    end
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL miss_error_held both=%b got bad_cycles=%0d exp 0", both, busy);
    end
    csr = '0;
    tick();
    tick();
    checks++;
    if (csrFb.error !== 1'b0) begin
      errors++;
      $display("FAIL miss_error_cleared both=%b got=%b exp=0", both, csrFb.error);
    end
  endtask

  task automatic test_timeout();
    int high;
    int got_cycle;
    csr.read = 1'b1;
    csr.address = 32'h0001_0004;
    csrOutFb[0].ready = 1'b1;
    csrOutFb[0].rdata = 32'h1111_1111;
    high = 0;
    got_cycle = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (csrOut[1].read) high++;
      if (csrFb.ready) begin
        got_cycle = i;
        break;
      end
    end
    csrOutFb = '0;
    checks++;
    if (high !== 9 || got_cycle !== 10) begin
      errors++;
      $display("FAIL timeout_timing got high=%0d ready_cycle=%0d exp 9 10", high, got_cycle);
    end
    checks++;
    if (csrFb.error !== 1'b1 || csrFb.rdata !== 32'h0 || csrOut[1].read !== 1'b0) begin
      errors++;
      $display("FAIL timeout_response got err=%b rdata=%h req=%b exp 1 0 0", csrFb.error, csrFb.rdata, csrOut[1].read);
    end
    csr = '0;
    tick();
    tick();
  endtask

  task automatic test_coincident();
    csr.read = 1'b1;
    csr.address = 32'h0001_0020;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (csrOut[1].read !== 1'b1 || csrFb.ready !== 1'b0) begin
      errors++;
      $display("FAIL coincident_pre got req=%b rdy=%b exp 1 0", csrOut[1].read, csrFb.ready);
    end
    csrOutFb[1].ready = 1'b1;
    csrOutFb[1].rdata = 32'h55AA_0001;
    tick();
    csrOutFb[1] = '0;
    checks++;
    if (csrFb.ready !== 1'b1 || csrFb.error !== 1'b0 || csrFb.rdata !== 32'h55AA_0001) begin
      errors++;
      $display("FAIL coincident_response got rdy=%b err=%b rdata=%h exp 1 0 55aa0001", csrFb.ready, csrFb.error, csrFb.rdata);
    end
    csr = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    csr.read = 1'b1;
    csr.address = 32'h0002_0040;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (csrOut !== '0 || csrFb !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got out=%h fb=%h exp 0", csrOut, csrFb);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (csrOut[2].read !== 1'b1 || csrOut[2].address !== 32'h0000_0040) begin
      errors++;
      $display("FAIL reset_mid_reissue got rd=%b addr=%h exp 1 00000040", csrOut[2].read, csrOut[2].address);
    end
    csrOutFb[2].ready = 1'b1;
    csrOutFb[2].rdata = 32'h0000_00AB;
    tick();
    csrOutFb[2] = '0;
    checks++;
    if (csrFb.ready !== 1'b1 || csrFb.rdata !== 32'h0000_00AB) begin
      errors++;
      $display("FAIL reset_mid_response got rdy=%b rdata=%h exp 1 000000ab", csrFb.ready, csrFb.rdata);
    end
    csr = '0;
    tick();
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_read();
    test_write_hold();
    test_miss(1'b0);
    test_miss(1'b1);
    test_timeout();
    test_coincident();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
